// File: rtl/ram_1rw_byte_mask_arb_pkg.sv
// Shared types for the two-requester RAM arbiter: requester identity and the
// winner-selection rule.
package ram_arb_pkg;

    typedef enum logic {REQ0, REQ1} req_id_e;

    localparam int ARB_DEF_DATA_W = 64;
    localparam int ARB_DEF_DEPTH  = 512;

    // Request struct template; the top re-declares it with its own widths.
    typedef struct packed {
        logic                            wr;
        logic [$clog2(ARB_DEF_DEPTH)-1:0] addr;
        logic [ARB_DEF_DATA_W-1:0]       data;
        logic [ARB_DEF_DATA_W/8-1:0]     mask;
    } req_def_s;

    // A lone requester wins outright; on contention the priority pointer decides.
    function automatic req_id_e pick_winner(input logic [1:0] val, input req_id_e prio);
        req_id_e w;
        w = REQ0;
        if (val[0] && val[1]) w = prio;
        else if (val[1])      w = REQ1;
        return w;
    endfunction

endpackage

// File: rtl/ram_1rw_byte_mask_arb_if.sv
// Request/response bundle for both requesters of the shared RAM arbiter.
interface ram_1rw_byte_mask_arb_if #(
    parameter int DATA_W      = 64,
    parameter int DATA_MASK_W = DATA_W/8,
    parameter int ADDR_W      = 9
);
    logic [1:0]                  req_val;
    logic [1:0]                  req_rdy;
    logic [1:0]                  req_wr;
    logic [1:0][ADDR_W-1:0]      req_addr;
    logic [1:0][DATA_W-1:0]      req_data;
    logic [1:0][DATA_MASK_W-1:0] req_mask;
    logic [1:0]                  resp_val;
    logic [1:0]                  resp_rdy;
    logic [DATA_W-1:0]           resp_data;

    modport master (
        output req_val, req_wr, req_addr, req_data, req_mask, resp_rdy,
        input  req_rdy, resp_val, resp_data
    );

    modport slave (
        input  req_val, req_wr, req_addr, req_data, req_mask, resp_rdy,
        output req_rdy, resp_val, resp_data
    );
endinterface

// File: rtl/ram_1rw_byte_mask_sync.sv
// Single-port RAM with byte write enables and a registered read port; every
// enabled access reloads the output register. Contents are never reset.
module ram_1rw_byte_mask_sync #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en_a,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [DATA_W-1:0]     din_a,
    input  logic [DATA_W/8-1:0]   wr_mask_a,
    output logic [DATA_W-1:0]     dout_a
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en_a) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_mask_a[b]) mem[addr_a][b*8 +: 8] <= din_a[b*8 +: 8];
            end
            dout_a <= mem[addr_a];
        end
    end
endmodule

// File: rtl/ram_1rw_byte_mask_arb.sv
// Round-robin arbiter/sequencer sharing one byte-masked synchronous RAM between
// two requesters; holds off all accesses while read data awaits consumption.
module ram_1rw_byte_mask_arb
    import ram_arb_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int DATA_MASK_W = DATA_W/8,
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    ram_1rw_byte_mask_arb_if.slave   bus
);
    typedef struct packed {
        logic                   wr;
        logic [ADDR_W-1:0]      addr;
        logic [DATA_W-1:0]      data;
        logic [DATA_MASK_W-1:0] mask;
    } req_t;

    logic              pend;
    req_id_e           own;
    req_id_e           prio;
    req_id_e           g;
    logic              gsel;
    logic              own_rdy;
    logic              can_issue;
    logic              acc;
    req_t              win;
    logic              en_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] din_a;
    logic [DATA_W/8-1:0] wr_mask_a;
    logic [DATA_W-1:0] dout_a;

    assign g       = pick_winner(bus.req_val, prio);
    assign gsel    = (g == REQ1);
    assign own_rdy = (own == REQ1) ? bus.resp_rdy[1] : bus.resp_rdy[0];

    // resp_val[own] mirrors pend, so the consume term reduces to own_rdy.
    assign can_issue = !pend || own_rdy;
    assign acc       = rst && can_issue && (|bus.req_val);

    always_comb begin
        win      = '0;
        win.wr   = bus.req_wr[gsel];
        win.addr = bus.req_addr[gsel];
        win.data = bus.req_data[gsel];
        win.mask = bus.req_mask[gsel];
    end

    assign bus.req_rdy  = gsel ? {acc, 1'b0} : {1'b0, acc};
    assign bus.resp_val = (own == REQ1) ? {pend, 1'b0} : {1'b0, pend};
    assign bus.resp_data = dout_a;

    assign en_a      = acc;
    assign addr_a    = win.addr;
    assign din_a     = win.data;
    assign wr_mask_a = win.wr ? win.mask : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= 1'b0;
            own  <= REQ0;
            prio <= REQ0;
        end else begin
            if (acc) prio <= (g == REQ0) ? REQ1 : REQ0;
            // A new read in the consuming cycle keeps pend set and retargets own.
            if (acc && !win.wr) begin
                pend <= 1'b1;
                own  <= g;
            end else if (pend && own_rdy) begin
                pend <= 1'b0;
            end
        end
    end

    ram_1rw_byte_mask_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .en_a      (en_a),
        .addr_a    (addr_a),
        .din_a     (din_a),
        .wr_mask_a (wr_mask_a),
        .dout_a    (dout_a)
    );
endmodule

// File: tb/tb_ram_1rw_byte_mask_arb.sv
// Scoreboard bench for ram_1rw_byte_mask_arb: directed requests push expected
// read responses; a monitor pops them as responses are consumed.
module tb_ram_1rw_byte_mask_arb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_1rw_byte_mask_arb_if #(.DATA_W(64), .DATA_MASK_W(8), .ADDR_W(9)) bus ();

    ram_1rw_byte_mask_arb #(.DATA_W(64), .DATA_MASK_W(8), .DEPTH(512), .ADDR_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [63:0] data;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_val  = '0;
        bus.req_wr   = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.req_mask = '0;
    endtask

    task automatic wait_rdy(input int id, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.req_rdy[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_rdy_timeout: requester %0d got no grant in 20 cycles", id);
        end
    endtask

    task automatic do_write(input int id, input int addr, input logic [63:0] data, input logic [7:0] mask);
        logic ok;
        bus.req_val[id]  = 1'b1;
        bus.req_wr[id]   = 1'b1;
        bus.req_addr[id] = 9'(addr);
        bus.req_data[id] = data;
        bus.req_mask[id] = mask;
        wait_rdy(id, ok);
        tick();
        bus.req_val[id] = 1'b0;
    endtask

    task automatic do_read(input int id, input int addr, input logic [63:0] expv, input bit push);
        logic ok;
        bus.req_val[id]  = 1'b1;
        bus.req_wr[id]   = 1'b0;
        bus.req_addr[id] = 9'(addr);
        wait_rdy(id, ok);
        if (ok && push) sbq.push_back('{id, expv});
        tick();
        bus.req_val[id] = 1'b0;
        if (push) begin
            chk("read_latency_val", 64'(bus.resp_val), (id == 1) ? 64'h2 : 64'h1);
            chk("read_latency_data", bus.resp_data, expv);
        end
    endtask

    // Monitor: every consumed response must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.resp_val == 2'b11) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_val_onehot: got %b", bus.resp_val);
                end
                for (int i = 0; i < 2; i++) begin
                    if (bus.resp_val[i] && bus.resp_rdy[i]) begin
                        checks++;
                        if (sbq.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_resp: requester %0d data %h, none expected", i, bus.resp_data);
                        end else begin
                            e = sbq.pop_front();
                            if (e.id != i || bus.resp_data !== e.data) begin
                                errors++;
                                $display("FAIL resp_compare: got req%0d data %h expected req%0d data %h",
                                         i, bus.resp_data, e.id, e.data);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        drive_idle();
        bus.resp_rdy = 2'b00;

        // Reset held with both requesters valid; these writes preload addrs 1 and 2.
        bus.req_val     = 2'b11;
        bus.req_wr      = 2'b11;
        bus.req_addr[0] = 9'd1;
        bus.req_data[0] = 64'h10;
        bus.req_mask[0] = 8'hFF;
        bus.req_addr[1] = 9'd2;
        bus.req_data[1] = 64'h20;
        bus.req_mask[1] = 8'hFF;
        repeat (3) @(negedge clk);
        chk("reset_req_rdy", 64'(bus.req_rdy), 64'h0);
        chk("reset_resp_val", 64'(bus.resp_val), 64'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("first_grant_req0", 64'(bus.req_rdy), 64'h1);
        tick();
        @(negedge clk);
        chk("second_grant_req1", 64'(bus.req_rdy), 64'h2);
        tick();
        drive_idle();
        bus.resp_rdy = 2'b11;

        // Masked write then read.
        do_write(0, 5, 64'h1122334455667788, 8'hFF);
        do_write(0, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        do_read(0, 5, 64'h11223344AAAAAAAA, 1'b1);
        do_write(0, 7, 64'hDEADBEEFCAFEF00D, 8'hFF);
        do_write(1, 3, 64'h33, 8'hFF);

        // Contention: prio points at req0 after req1's last accept.
        bus.req_wr      = 2'b00;
        bus.req_addr[0] = 9'd1;
        bus.req_addr[1] = 9'd2;
        bus.req_val     = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("contention_grant", 64'(bus.req_rdy), (k % 2 == 1) ? 64'h2 : 64'h1);
            if (k > 0) chk("contention_resp_val", 64'(bus.resp_val), (k % 2 == 1) ? 64'h1 : 64'h2);
            sbq.push_back('{k % 2, (k % 2 == 1) ? 64'h20 : 64'h10});
            tick();
        end
        drive_idle();
        tick();
        tick();

        // Backpressure on req1 while req0 offers a write and req1 a further read.
        bus.resp_rdy = 2'b01;
        do_read(1, 3, 64'h33, 1'b1);
        bus.req_wr[0]   = 1'b1;
        bus.req_addr[0] = 9'd9;
        bus.req_data[0] = 64'h99;
        bus.req_mask[0] = 8'hFF;
        bus.req_wr[1]   = 1'b0;
        bus.req_addr[1] = 9'd1;
        bus.req_val     = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_req_rdy_blocked", 64'(bus.req_rdy), 64'h0);
            chk("bp_data_hold", bus.resp_data, 64'h33);
            tick();
        end
        bus.resp_rdy = 2'b11;
        @(negedge clk);
        chk("bp_write_with_consume", 64'(bus.req_rdy), 64'h1);
        tick();
        bus.req_val[0] = 1'b0;
        @(negedge clk);
        chk("bp_req1_read_grant", 64'(bus.req_rdy), 64'h2);
        sbq.push_back('{1, 64'h10});
        tick();
        drive_idle();
        tick();

        // Zero-mask write leaves contents intact and produces no response.
        do_write(0, 7, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        chk("zero_mask_no_resp", 64'(bus.resp_val), 64'h0);
        do_read(0, 7, 64'hDEADBEEFCAFEF00D, 1'b1);
        do_read(1, 9, 64'h99, 1'b1);
        tick();

        // Reset while a response is being presented.
        bus.resp_rdy = 2'b00;
        do_read(0, 2, 64'h20, 1'b0);
        chk("mid_read_resp_val", 64'(bus.resp_val), 64'h1);
        #1 rst = 1'b0;
        #1 chk("async_resp_drop", 64'(bus.resp_val), 64'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.resp_rdy = 2'b11;
        repeat (5) tick();
        chk("no_resp_after_reset", 64'(bus.resp_val), 64'h0);

        chk("scoreboard_drained", 64'(sbq.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
